// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - fetch stage bus: instruction memory port, redirect input and decode-side output
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ready_out;
  logic        valid_out;
  logic [31:0] instr_out;
  logic [31:0] pc_out;

  modport master (
    output imem_req, imem_addr, valid_out, instr_out, pc_out,
    input  imem_rdata, redirect_valid, redirect_pc, ready_out
  );

  modport slave (
    input  imem_req, imem_addr, valid_out, instr_out, pc_out,
    output imem_rdata, redirect_valid, redirect_pc, ready_out
  );
endinterface

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch stage with a 2-entry {pc, instr} output queue
// FETCH_PERF_CNT_EN adds saturating stall_cycles and fetch_count outputs
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  fetch_if.master     bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] fetch_count
`endif
);

  logic [31:0] pc_reg;
  logic [31:0] issued_pc;
  logic        inflight;
  logic [31:0] q_pc    [QDEPTH];
  logic [31:0] q_instr [QDEPTH];
  logic        head;
  logic        tail;
  logic [1:0]  count;

  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occupancy;

  assign bus.valid_out = (count != 2'd0);
  assign bus.pc_out    = q_pc[head];
  assign bus.instr_out = q_instr[head];

  assign pop  = bus.valid_out && bus.ready_out;
  // The response for last cycle's request is discarded if a redirect flushes the stage now
  assign push = inflight && !bus.redirect_valid;

  // Credit rule: buffered plus in-flight entries after this cycle's pop must leave room
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = reset && !bus.redirect_valid && (occupancy < 3'd2);

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg    <= RESET_PC;
      issued_pc <= 32'h0;
      inflight  <= 1'b0;
      head      <= 1'b0;
      tail      <= 1'b0;
      count     <= 2'd0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc[i]    <= 32'h0;
        q_instr[i] <= 32'h0;
      end
    end else begin
      inflight <= issue;
      if (issue) begin
        issued_pc <= pc_reg;
      end
      if (bus.redirect_valid) begin
        pc_reg <= bus.redirect_pc & ~32'h3;
        count  <= 2'd0;
        head   <= 1'b0;
        tail   <= 1'b0;
      end else begin
        if (issue) begin
          pc_reg <= pc_reg + 32'd4;
        end
        if (push) begin
          q_pc[tail]    <= issued_pc;
          q_instr[tail] <= bus.imem_rdata;
          tail          <= ~tail;
        end
        if (pop) begin
          head <= ~head;
        end
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= 32'h0;
      fetch_count  <= 32'h0;
    end else begin
      if (bus.valid_out && !bus.ready_out && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (push && (fetch_count != 32'hFFFF_FFFF)) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end
`endif

endmodule
